// File: rtl/gear_input_conditioner.sv
// Conditions the shift-up, shift-down and brake buttons for the gearbox FSM:
// synchronise, debounce, turn presses into one-cycle pulses and arbitrate them.
module gear_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_up,
    input  logic raw_down,
    input  logic raw_brake,
    output logic shift_up,
    output logic shift_down,
    output logic brake,
    output logic conflict
);

    localparam int NCH   = 3;
    localparam int CH_UP = 0;
    localparam int CH_DN = 1;
    localparam int CH_BR = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] r_s1;
    logic [NCH-1:0] r_s2;
    logic [NCH-1:0] r_db;
    logic [NCH-1:0] w_accept;
    logic [NCH-1:0] w_rise;
    logic           w_up_evt;
    logic           w_down_evt;
    logic           r_shift_up;
    logic           r_shift_down;
    logic           r_conflict;

    assign w_raw = {raw_brake, raw_down, raw_up};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Each channel: the counter only runs while s2 disagrees with the stable
    // level; any agreement wipes the partial count.
    for (genvar g = 0; g < NCH; g++) begin : g_chan
        logic [CNT_W-1:0] r_cnt;

        assign w_accept[g] = (r_s2[g] != r_db[g]) && (r_cnt == CNT_LAST);
        assign w_rise[g]   = w_accept[g] & r_s2[g];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_db[g] <= 1'b0;
                r_cnt   <= '0;
            end else if (r_s2[g] == r_db[g]) begin
                r_cnt <= '0;
            end else if (w_accept[g]) begin
                r_db[g] <= r_s2[g];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Up presses are dropped while the brake is already held; down is allowed.
    assign w_up_evt   = w_rise[CH_UP] & ~r_db[CH_BR];
    assign w_down_evt = w_rise[CH_DN];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift_up   <= 1'b0;
            r_shift_down <= 1'b0;
            r_conflict   <= 1'b0;
        end else begin
            r_shift_up   <= w_up_evt & ~w_down_evt;
            r_shift_down <= w_down_evt & ~w_up_evt;
            r_conflict   <= w_up_evt & w_down_evt;
        end
    end

    assign shift_up   = r_shift_up;
    assign shift_down = r_shift_down;
    assign conflict   = r_conflict;
    assign brake      = r_db[CH_BR];

endmodule
